// File: rtl/stats_reporter_if.sv
// stats_reporter_if: byte stream from the reporter to the UART.
// Master drives data/valid, slave answers with ready.
interface stats_reporter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/stats_reporter.sv
// stats_reporter: snapshots pet stats and streams an 11-byte
// ASCII frame ('S', 8 hex digits, CR, LF) on timer or request.
module stats_reporter #(
  parameter logic [23:0] REPORT_PERIOD = 24'd10_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    report_req,
  input  logic [3:0]              hunger,
  input  logic [3:0]              happiness,
  input  logic [3:0]              health,
  input  logic [3:0]              hygiene,
  input  logic [3:0]              energy,
  input  logic [3:0]              social,
  input  logic [6:0]              status,
  stats_reporter_if.master        tx,
  output logic                    busy,
  output logic                    frame_done,
  output logic [7:0]              frame_count
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [23:0] cnt;
  logic        tick;
  logic        pending;
  logic        trig;
  logic        start;
  logic        accept;
  logic        last;
  logic [3:0]  idx;
  logic [3:0]  idx_n;
  logic [23:0] snap;
  logic [6:0]  snap_st;
  logic [7:0]  nxt_byte;
  logic [7:0]  data_q;
  logic        valid_q;

  function automatic logic [7:0] hex(input logic [3:0] v);
    return (v < 4'd10) ? 8'h30 + {4'h0, v}
                       : 8'h37 + {4'h0, v};
  endfunction

  assign tick  = (cnt == REPORT_PERIOD - 24'd1);
  assign trig  = tick | report_req | pending;
  assign idx_n = idx + 4'd1;

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;

  // free-running report period counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 24'd1;
    end
  end

  // one-deep request memory; late requests merge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (start) begin
      pending <= 1'b0;
    end else if (tick | report_req) begin
      pending <= 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // next state and handshake decode
  always_comb begin
    state_d = state;
    start   = 1'b0;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && trig) begin
          start   = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx.tx_ready) begin
          accept = 1'b1;
          if (idx == 4'd10) begin
            last    = 1'b1;
            state_d = GAP;
          end
        end
      end
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // byte that follows the one currently on the bus
  always_comb begin
    nxt_byte = 8'h53;
    case (idx_n)
      4'd1:  nxt_byte = hex(snap[23:20]);
      4'd2:  nxt_byte = hex(snap[19:16]);
      4'd3:  nxt_byte = hex(snap[15:12]);
      4'd4:  nxt_byte = hex(snap[11:8]);
      4'd5:  nxt_byte = hex(snap[7:4]);
      4'd6:  nxt_byte = hex(snap[3:0]);
      4'd7:  nxt_byte = hex({1'b0, snap_st[6:4]});
      4'd8:  nxt_byte = hex(snap_st[3:0]);
      4'd9:  nxt_byte = 8'h0D;
      4'd10: nxt_byte = 8'h0A;
      default: nxt_byte = 8'h53;
    endcase
  end

  // frame datapath: snapshot, byte stepping, completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap        <= '0;
      snap_st     <= '0;
      idx         <= '0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 8'h00;
    end else begin
      frame_done <= last;
      if (start) begin
        snap    <= {hunger, happiness, health,
                    hygiene, energy, social};
        snap_st <= status;
        idx     <= 4'd0;
        data_q  <= 8'h53;
        valid_q <= 1'b1;
        busy    <= 1'b1;
      end else if (last) begin
        valid_q     <= 1'b0;
        busy        <= 1'b0;
        frame_count <= frame_count + 8'd1;
      end else if (accept) begin
        idx    <= idx_n;
        data_q <= nxt_byte;
      end
    end
  end

endmodule

// File: doc/stats_reporter.md
Name: stats_reporter

Overview:
- Downstream consumer of the pet's stat registers and 7-bit status vector.
- Periodically, or on request, snapshots all six 4-bit stats plus status and serialises them as an 11-byte ASCII frame.
- Bytes leave over a valid/ready byte handshake into the UART transmitter, so a host terminal can log the pet's state.

Parameters:
- REPORT_PERIOD, 24'd10_000_000: clk cycles between automatic reports. Legal range is 2 or more.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  when low, no new frame starts; a frame in progress still completes
- report_req  input  1  single-cycle request for an immediate frame
- hunger  input  4  stat value
- happiness  input  4  stat value
- health  input  4  stat value
- hygiene  input  4  stat value
- energy  input  4  stat value
- social  input  4  stat value
- status  input  7  status vector
- tx_data  output  8  byte to the UART transmitter
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  transmitter accepts the byte
- busy  output  1  a frame is in progress
- frame_done  output  1  one-cycle pulse after the last byte is accepted
- frame_count  output  8  number of completed frames, wraps at 255 to 0

Behaviour:
- Reset (asynchronous, rst_n low):
  - Outputs: tx_data=8'h00, tx_valid=0, busy=0, frame_done=0, frame_count=0.
  - Internal: period counter=0, pending=0, byte index=0, FSM in IDLE.
  - Reset mid-frame aborts the frame immediately. No partial completion and no frame_done.
- Period counter:
  - Free-running from 0 to REPORT_PERIOD-1, then wraps to 0.
  - tick=1 in the cycle the counter equals REPORT_PERIOD-1.
  - Counts regardless of enable or busy.
- Trigger:
  - trig = tick OR report_req OR pending.
  - If trig is set in IDLE with enable=1, a frame starts at that edge.
  - If tick or report_req arrives while busy, or while in IDLE with enable=0, pending is set to 1. Pending holds one request only; extra requests merge.
  - pending clears on the edge that starts a frame.
- FSM states: IDLE, SEND, GAP.
  - IDLE -> SEND on trig with enable=1. On that edge:
    - Snapshot all stats and status into internal registers.
    - Set byte index to 0, tx_valid=1, busy=1, tx_data='S' (8'h53).
  - SEND:
    - On tx_valid AND tx_ready, the byte index increments and tx_data loads the next byte in the same edge, so tx_valid stays high.
    - Transitions to GAP on acceptance of byte 10.
    - tx_data and tx_valid hold stable while tx_ready=0.
  - GAP (exactly one cycle):
    - tx_valid=0, busy=0, frame_done=1, frame_count increments.
    - Then returns to IDLE.
    - If pending is set, the next frame starts on the following edge, giving a minimum 2-cycle tx_valid gap between frames.
- Frame format, 11 bytes, in order:
  - 'S'
  - hex(hunger), hex(happiness), hex(health), hex(hygiene), hex(energy), hex(social)
  - hex({1'b0,status[6:4]}), hex(status[3:0])
  - 8'h0D, 8'h0A
- Hex encoding: values 0-9 map to 8'h30-8'h39; values 10-15 map to 8'h41-8'h46 (uppercase).
- Stat changes during a frame do not affect it; only the snapshot is sent.
- Latency: report_req high at edge k in IDLE gives tx_valid=1 after edge k. With tx_ready held high, the frame takes 11 cycles, then 1 GAP cycle.
- enable dropping mid-frame has no effect on the current frame.
- A tick in the same cycle as report_req counts as one request.

Test Plan:
- Stats hunger=3, happiness=A, health=F, hygiene=0, energy=9, social=C, status=7'h5B; report_req pulse; tx_ready=1 -> bytes 53 33 41 46 30 39 43 35 42 0D 0A on consecutive cycles, then frame_done pulse and frame_count=1.
- Same frame with tx_ready toggling 1/0 each cycle -> identical byte sequence, tx_data stable on every ready=0 cycle, 11 handshakes total.
- REPORT_PERIOD=20, enable=1, tx_ready=1, no req -> frames start every 20 cycles; frame_count=3 after 60+ cycles.
- report_req pulsed twice during a frame with tx_ready=0 held for 10 cycles -> exactly one extra frame follows, with tx_valid low for 2 cycles between frames.
- Change all stats to F while mid-frame -> remaining bytes still reflect the snapshot values.
- rst_n low for 1 cycle at byte 5 -> tx_valid=0, busy=0 immediately; no frame_done; frame_count unchanged at 0.
